// File: rtl/dm_sb_arbiter_pkg.sv
// Shared types for the debug-module system-bus arbiter.
// Contents:
//   lock_state_e - state of the grant-lock FSM. While the bus has not yet accepted
//                  a request, the selection must not change.
package dm_sb_arbiter_pkg;

  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dm_sb_arbiter_checker.sv
// Protocol assertions for dm_sb_arbiter. This block has no functional outputs.
// Ports:
//   clk_i, rst_ni, dmactive_i  clock, reset and arbiter enable
//   gnt, r_valid               arbiter grant and response vectors
//   lock_held, lock_idx        grant-lock state
//   req                        requester request vector
//   push, full                 ID FIFO push and full flag
module dm_sb_arbiter_checker
  import dm_sb_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdW    = 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              dmactive_i,
  input logic [NumReq-1:0] gnt,
  input logic [NumReq-1:0] r_valid,
  input logic              lock_held,
  input logic [IdW-1:0]    lock_idx,
  input logic [NumReq-1:0] req,
  input logic              push,
  input logic              full
);

  gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt));

  rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_valid));

  // The bus needs a stable request until it is granted, so a locked requester
  // must not withdraw its request.
  req_stable_locked : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_held && dmactive_i) |-> req[lock_idx]);

  no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));

endmodule

// File: rtl/dm_sb_id_fifo.sv
// Synchronous FIFO that holds the requester IDs of granted bus transactions.
// Responses are routed back in grant order, and the head entry names the owner
// of the next response.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear; empties the FIFO
//   push_i, data_i  enqueue an ID; ignored when the FIFO is full
//   pop_i           dequeue the head entry; ignored when the FIFO is empty
//   data_o          head entry
//   full_o, empty_o occupancy flags
module dm_sb_id_fifo
  import dm_sb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PtrW-1:0]             wptr_q;
  logic [PtrW-1:0]             rptr_q;
  logic [CntW-1:0]             cnt_q;
  logic                        push_ok;
  logic                        pop_ok;

  // Pointers wrap explicitly, so DEPTH does not have to be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  // Qualify push and pop against the occupancy flags.
  always_comb begin
    full_o  = (cnt_q == CntW'(DEPTH));
    empty_o = (cnt_q == CntW'(0));
    push_ok = push_i & ~full_o;
    pop_ok  = pop_i & ~empty_o;
    data_o  = mem_q[rptr_q];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= next_ptr(wptr_q);
      end
      if (pop_ok) begin
        rptr_q <= next_ptr(rptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dm_sb_arbiter.sv
// Round-robin arbiter that shares the debug-module system-bus master port
// between NumReq requesters.
// - While a request waits for the bus grant, that request is locked.
// - Responses are routed in order through an outstanding-ID FIFO.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   dmactive_i           low clears arbiter state and blocks requests
//   req_i/add_i/we_i/wdata_i/be_i  per-requester request bundle
//   gnt_o, r_valid_o     per-requester grant and response valid (one-hot or zero)
//   r_rdata_o            response data, shared by all requesters
//   master_*_o           bus request bundle, driven from the selected requester
//   master_gnt_i, master_r_valid_i, master_r_rdata_i  bus handshake and response
//   resp_err_o           bus response arrived with no outstanding transaction
module dm_sb_arbiter
  import dm_sb_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned BusWidth = 32,
  parameter int unsigned MaxOut   = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 dmactive_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][BusWidth-1:0]      add_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][BusWidth-1:0]      wdata_i,
  input  logic [NumReq-1:0][BusWidth/8-1:0]    be_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    r_valid_o,
  output logic [BusWidth-1:0]                  r_rdata_o,
  output logic                                 master_req_o,
  output logic [BusWidth-1:0]                  master_add_o,
  output logic                                 master_we_o,
  output logic [BusWidth-1:0]                  master_wdata_o,
  output logic [BusWidth/8-1:0]                master_be_o,
  input  logic                                 master_gnt_i,
  input  logic                                 master_r_valid_i,
  input  logic [BusWidth-1:0]                  master_r_rdata_i,
  output logic                                 resp_err_o
);

  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef logic [IdW-1:0] sb_id_t;

  lock_state_e lock_state_q, lock_state_d;
  sb_id_t      lock_idx_q, lock_idx_d;
  sb_id_t      prio_q, prio_d;
  sb_id_t      scan_sel;
  sb_id_t      sel;
  logic [IdW:0] cand_wide;
  logic        found;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  sb_id_t      head_id;

  // Next requester in round-robin order. The wrap at NumReq-1 is explicit.
  function automatic sb_id_t next_id(input sb_id_t id);
    if (id == sb_id_t'(NumReq - 1)) begin
      return '0;
    end else begin
      return id + sb_id_t'(1);
    end
  endfunction

  // Round-robin scan. Pick the first active request starting at prio_q.
  always_comb begin
    scan_sel  = prio_q;
    found     = 1'b0;
    cand_wide = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      // prio_q + k is always below 2*NumReq, so one subtraction is enough for the modulo.
      cand_wide = {1'b0, prio_q} + (IdW + 1)'(k);
      if (cand_wide >= (IdW + 1)'(NumReq)) begin
        cand_wide = cand_wide - (IdW + 1)'(NumReq);
      end else begin
        cand_wide = cand_wide;
      end
      if (!found && req_i[cand_wide[IdW-1:0]]) begin
        scan_sel = cand_wide[IdW-1:0];
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Bus request muxing, grant and response routing, and lock/priority next state.
  always_comb begin
    sel          = (lock_state_q == LOCK_HELD) ? lock_idx_q : scan_sel;
    // The full flag is registered, so a pop in this cycle cannot re-open the request path.
    master_req_o   = req_i[sel] & ~fifo_full & dmactive_i & rst_ni;
    master_add_o   = add_i[sel];
    master_we_o    = we_i[sel];
    master_wdata_o = wdata_i[sel];
    master_be_o    = be_i[sel];
    push           = master_req_o & master_gnt_i;
    pop            = master_r_valid_i & ~fifo_empty;
    r_rdata_o      = master_r_rdata_i;
    resp_err_o     = master_r_valid_i & fifo_empty & rst_ni;

    gnt_o = '0;
    if (push) begin
      gnt_o[sel] = 1'b1;
    end else begin
      gnt_o = '0;
    end

    r_valid_o = '0;
    if (pop) begin
      r_valid_o[head_id] = 1'b1;
    end else begin
      r_valid_o = '0;
    end

    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx_q;
    prio_d       = prio_q;
    if (!dmactive_i) begin
      lock_state_d = LOCK_IDLE;
      lock_idx_d   = '0;
      prio_d       = '0;
    end else begin
      if (push) begin
        prio_d = next_id(sel);
      end else begin
        prio_d = prio_q;
      end
      case (lock_state_q)
        LOCK_IDLE: begin
          if (master_req_o && !master_gnt_i) begin
            lock_state_d = LOCK_HELD;
            lock_idx_d   = sel;
          end else begin
            lock_state_d = LOCK_IDLE;
          end
        end
        LOCK_HELD: begin
          if (push) begin
            lock_state_d = LOCK_IDLE;
          end else if (!req_i[lock_idx_q]) begin
            // The requester withdrew its request. Release the lock so the arbiter does not stall.
            lock_state_d = LOCK_IDLE;
          end else begin
            lock_state_d = LOCK_HELD;
          end
        end
        default: lock_state_d = LOCK_IDLE;
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_state_q <= LOCK_IDLE;
      lock_idx_q   <= '0;
      prio_q       <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx_q   <= lock_idx_d;
      prio_q       <= prio_d;
    end
  end

  dm_sb_id_fifo #(
    .DEPTH(MaxOut),
    .WIDTH(IdW)
  ) i_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(~dmactive_i),
    .push_i (push),
    .data_i (sel),
    .pop_i  (pop),
    .data_o (head_id),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  dm_sb_arbiter_checker #(
    .NumReq(NumReq),
    .IdW   (IdW)
  ) i_checker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .dmactive_i(dmactive_i),
    .gnt       (gnt_o),
    .r_valid   (r_valid_o),
    .lock_held (lock_state_q == LOCK_HELD),
    .lock_idx  (lock_idx_q),
    .req       (req_i),
    .push      (push),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_dm_sb_arbiter.sv
// Directed self-checking bench for dm_sb_arbiter (NumReq=2, BusWidth=32, MaxOut=2).
// Inputs change 1 time unit after the rising edge.
// The combinational outputs are checked 1 time unit after that, well before the next edge.
module tb_dm_sb_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              dmactive_i;
  logic [1:0]        req_i;
  logic [1:0][31:0]  add_i;
  logic [1:0]        we_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0][3:0]   be_i;
  logic [1:0]        gnt_o;
  logic [1:0]        r_valid_o;
  logic [31:0]       r_rdata_o;
  logic              master_req_o;
  logic [31:0]       master_add_o;
  logic              master_we_o;
  logic [31:0]       master_wdata_o;
  logic [3:0]        master_be_o;
  logic              master_gnt_i;
  logic              master_r_valid_i;
  logic [31:0]       master_r_rdata_i;
  logic              resp_err_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADD0 = 32'hA000_0000;
  localparam logic [31:0] ADD1 = 32'hB000_0004;

  always #5 clk_i = ~clk_i;

  dm_sb_arbiter #(.NumReq(2), .BusWidth(32), .MaxOut(2)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .dmactive_i      (dmactive_i),
    .req_i           (req_i),
    .add_i           (add_i),
    .we_i            (we_i),
    .wdata_i         (wdata_i),
    .be_i            (be_i),
    .gnt_o           (gnt_o),
    .r_valid_o       (r_valid_o),
    .r_rdata_o       (r_rdata_o),
    .master_req_o    (master_req_o),
    .master_add_o    (master_add_o),
    .master_we_o     (master_we_o),
    .master_wdata_o  (master_wdata_o),
    .master_be_o     (master_be_o),
    .master_gnt_i    (master_gnt_i),
    .master_r_valid_i(master_r_valid_i),
    .master_r_rdata_i(master_r_rdata_i),
    .resp_err_o      (resp_err_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    dmactive_i = 1'b1;
    req_i = 2'b11;
    master_gnt_i = 1'b1;
    master_r_valid_i = 1'b0;
    master_r_rdata_i = 32'h0;
    step();
    step();
    #1;
    checks++;
    if (master_req_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_master_req: got %b want 0", master_req_o);
    end
    checks++;
    if (gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_gnt: got %b want 00", gnt_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_gnt: got %b want 01", gnt_o);
    end
    checks++;
    if (master_add_o !== ADD0) begin
      failures++;
      $display("FAIL reset_first_add: got %h want %h", master_add_o, ADD0);
    end
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 4; c++) begin
      req_i = 2'b11;
      master_gnt_i = 1'b1;
      master_r_valid_i = (c > 0);
      master_r_rdata_i = 32'h1000 + c;
      #1;
      checks++;
      if (gnt_o !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt_o, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (c > 0) begin
        checks++;
        if (r_valid_o !== ((c % 2 == 1) ? 2'b01 : 2'b10)) begin
          failures++;
          $display("FAIL rr_rvalid[%0d]: got %b want %b", c, r_valid_o, (c % 2 == 1) ? 2'b01 : 2'b10);
        end
      end
      step();
    end
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h2000;
    #1;
    checks++;
    if (r_valid_o !== 2'b10 || r_rdata_o !== 32'h2000) begin
      failures++;
      $display("FAIL rr_drain: got %b/%h want 10/00002000", r_valid_o, r_rdata_o);
    end
    step();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_lock();
    for (int c = 0; c < 3; c++) begin
      req_i = 2'b10;
      master_gnt_i = 1'b0;
      #1;
      checks++;
      if (master_req_o !== 1'b1 || master_add_o !== ADD1 || gnt_o !== 2'b00) begin
        failures++;
        $display("FAIL lock_wait[%0d]: got req=%b add=%h gnt=%b want 1/%h/00", c, master_req_o, master_add_o, gnt_o, ADD1);
      end
      step();
    end
    req_i = 2'b11;
    #1;
    checks++;
    if (master_add_o !== ADD1 || gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL lock_hold: got add=%h gnt=%b want %h/00", master_add_o, gnt_o, ADD1);
    end
    step();
    master_gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL lock_grant: got %b want 10", gnt_o);
    end
    step();
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1;
    #1;
    checks++;
    if (r_valid_o !== 2'b10) begin
      failures++;
      $display("FAIL lock_resp: got %b want 10", r_valid_o);
    end
    step();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_full();
    req_i = 2'b11;
    master_gnt_i = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (master_req_o !== 1'b0 || gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL full_block: got req=%b gnt=%b want 0/00", master_req_o, gnt_o);
    end
    step();
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h3333_0000;
    #1;
    checks++;
    if (r_valid_o !== 2'b01 || master_req_o !== 1'b0) begin
      failures++;
      $display("FAIL full_pop: got rvalid=%b req=%b want 01/0", r_valid_o, master_req_o);
    end
    step();
    master_r_valid_i = 1'b0;
    #1;
    checks++;
    if (master_req_o !== 1'b1 || gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL full_reopen: got req=%b gnt=%b want 1/01", master_req_o, gnt_o);
    end
    step();
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1;
    #1;
    checks++;
    if (r_valid_o !== 2'b10) begin
      failures++;
      $display("FAIL full_drain1: got %b want 10", r_valid_o);
    end
    step();
    #1;
    checks++;
    if (r_valid_o !== 2'b01) begin
      failures++;
      $display("FAIL full_drain2: got %b want 01", r_valid_o);
    end
    step();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_ordering();
    req_i = 2'b01;
    master_gnt_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL order_gnt0: got %b want 01", gnt_o);
    end
    step();
    req_i = 2'b10;
    #1;
    checks++;
    if (gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL order_gnt1: got %b want 10", gnt_o);
    end
    step();
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'hAAAA_5555;
    #1;
    checks++;
    if (r_valid_o !== 2'b01 || r_rdata_o !== 32'hAAAA_5555) begin
      failures++;
      $display("FAIL order_respA: got %b/%h want 01/aaaa5555", r_valid_o, r_rdata_o);
    end
    step();
    master_r_rdata_i = 32'hBBBB_CCCC;
    #1;
    checks++;
    if (r_valid_o !== 2'b10 || r_rdata_o !== 32'hBBBB_CCCC) begin
      failures++;
      $display("FAIL order_respB: got %b/%h want 10/bbbbcccc", r_valid_o, r_rdata_o);
    end
    step();
    master_r_valid_i = 1'b0;
  endtask

  task automatic test_error();
    master_r_valid_i = 1'b1;
    #1;
    checks++;
    if (resp_err_o !== 1'b1 || r_valid_o !== 2'b00) begin
      failures++;
      $display("FAIL err_empty: got err=%b rvalid=%b want 1/00", resp_err_o, r_valid_o);
    end
    step();
    master_r_valid_i = 1'b0;
    #1;
    checks++;
    if (resp_err_o !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse: got %b want 0", resp_err_o);
    end
    req_i = 2'b01;
    master_gnt_i = 1'b1;
    step();
    req_i = 2'b11;
    dmactive_i = 1'b0;
    #1;
    checks++;
    if (master_req_o !== 1'b0 || gnt_o !== 2'b00) begin
      failures++;
      $display("FAIL err_dmactive_block: got req=%b gnt=%b want 0/00", master_req_o, gnt_o);
    end
    step();
    dmactive_i = 1'b1;
    req_i = 2'b00;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b1;
    #1;
    checks++;
    if (resp_err_o !== 1'b1 || r_valid_o !== 2'b00) begin
      failures++;
      $display("FAIL err_late_resp: got err=%b rvalid=%b want 1/00", resp_err_o, r_valid_o);
    end
    step();
    master_r_valid_i = 1'b0;
  endtask

  initial begin
    add_i[0] = ADD0;
    add_i[1] = ADD1;
    we_i = 2'b10;
    wdata_i[0] = 32'h0000_1111;
    wdata_i[1] = 32'h2222_0000;
    be_i[0] = 4'hF;
    be_i[1] = 4'h3;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_ordering();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
